// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundles the two requester ports and the memory-side bus
// of dmem_arbiter. Signal names keep the arbiter's point of view
// (i_ = into the arbiter, o_ = out of the arbiter).
// slave modport: the arbiter. master modport: requesters plus memory.
`timescale 1ns/1ps
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Requester m0 (CPU load/store stage)
  logic              i_m0_req;
  logic              i_m0_we;
  logic [ADDR_W-1:0] i_m0_addr;
  logic [DATA_W-1:0] i_m0_wdata;
  logic              o_m0_gnt;
  logic              o_m0_rvalid;
  logic [DATA_W-1:0] o_m0_rdata;
  // Requester m1 (DMA / debug loader)
  logic              i_m1_req;
  logic              i_m1_we;
  logic [ADDR_W-1:0] i_m1_addr;
  logic [DATA_W-1:0] i_m1_wdata;
  logic              o_m1_gnt;
  logic              o_m1_rvalid;
  logic [DATA_W-1:0] o_m1_rdata;
  // Memory side
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [DATA_W-1:0] i_mem_rdata;

  modport slave (
    input  i_m0_req, i_m0_we, i_m0_addr, i_m0_wdata,
    output o_m0_gnt, o_m0_rvalid, o_m0_rdata,
    input  i_m1_req, i_m1_we, i_m1_addr, i_m1_wdata,
    output o_m1_gnt, o_m1_rvalid, o_m1_rdata,
    output o_mem_we, o_mem_addr, o_mem_wdata,
    input  i_mem_rdata
  );

  modport master (
    output i_m0_req, i_m0_we, i_m0_addr, i_m0_wdata,
    input  o_m0_gnt, o_m0_rvalid, o_m0_rdata,
    output i_m1_req, i_m1_we, i_m1_addr, i_m1_wdata,
    input  o_m1_gnt, o_m1_rvalid, o_m1_rdata,
    input  o_mem_we, o_mem_addr, o_mem_wdata,
    output i_mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory (synchronous write,
// combinational read) between m0 (CPU) and m1 (DMA/debug loader).
// Default build: m0 has fixed priority; a hold counter forces one m1 grant
// after MAX_HOLD consecutive m0 grants while m1 waits.
// Optional macro DMEM_ARB_RR_EN: strict round-robin instead; the hold
// counter is not built and MAX_HOLD is ignored.
//
// Handshake: a requester raises req with we/addr/wdata and keeps all of
// them stable until the cycle in which its gnt is 1; that cycle consumes
// the request (write commits at the closing edge, read data is captured at
// the closing edge and shown with a one-cycle rvalid pulse afterwards).
// gnt is combinational from req and arbiter state; at most one gnt is high.
`timescale 1ns/1ps
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  dmem_arbiter_if.slave  bus
);

  logic              w_gnt_m0;
  logic              w_gnt_m1;
  logic              r_m0_rvalid;
  logic              r_m1_rvalid;
  logic [DATA_W-1:0] r_m0_rdata;
  logic [DATA_W-1:0] r_m1_rdata;

`ifdef DMEM_ARB_RR_EN
  // 0 = m0 owned the last grant, 1 = m1 did
  logic r_last_owner;

  // Round-robin grant: on contention the port not granted last time wins
  always_comb begin
    w_gnt_m0 = 1'b0;
    w_gnt_m1 = 1'b0;
    if (i_rst_n) begin
      if (bus.i_m0_req && bus.i_m1_req) begin
        if (r_last_owner) w_gnt_m0 = 1'b1;
        else              w_gnt_m1 = 1'b1;
      end else begin
        w_gnt_m0 = bus.i_m0_req;
        w_gnt_m1 = bus.i_m1_req;
      end
    end
  end

  // Remember the owner of every grant
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_last_owner <= 1'b0;
    end else if (w_gnt_m1) begin
      r_last_owner <= 1'b1;
    end else if (w_gnt_m0) begin
      r_last_owner <= 1'b0;
    end
  end
`else
  localparam logic [3:0] LP_MAX_HOLD = 4'(MAX_HOLD);

  // Consecutive m0 grants while m1 has been waiting, saturating
  logic [3:0] r_hold_cnt;

  // Priority grant: m0 wins contention until the hold counter saturates
  always_comb begin
    w_gnt_m0 = 1'b0;
    w_gnt_m1 = 1'b0;
    if (i_rst_n) begin
      if (bus.i_m0_req && bus.i_m1_req) begin
        if (r_hold_cnt == LP_MAX_HOLD) w_gnt_m1 = 1'b1;
        else                           w_gnt_m0 = 1'b1;
      end else begin
        w_gnt_m0 = bus.i_m0_req;
        w_gnt_m1 = bus.i_m1_req;
      end
    end
  end

  // Starvation guard: count m0 wins over a waiting m1, clear once m1 is served or idle
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_hold_cnt <= 4'd0;
    end else if (w_gnt_m1 || !bus.i_m1_req) begin
      r_hold_cnt <= 4'd0;
    end else if (w_gnt_m0 && (r_hold_cnt != LP_MAX_HOLD)) begin
      r_hold_cnt <= r_hold_cnt + 4'd1;
    end
  end
`endif

  // Memory-side mux: forward the granted port, drive zeros when idle
  always_comb begin
    bus.o_mem_we    = 1'b0;
    bus.o_mem_addr  = '0;
    bus.o_mem_wdata = '0;
    if (w_gnt_m0) begin
      bus.o_mem_we    = bus.i_m0_we;
      bus.o_mem_addr  = bus.i_m0_addr;
      bus.o_mem_wdata = bus.i_m0_wdata;
    end else if (w_gnt_m1) begin
      bus.o_mem_we    = bus.i_m1_we;
      bus.o_mem_addr  = bus.i_m1_addr;
      bus.o_mem_wdata = bus.i_m1_wdata;
    end
  end

  // Read response: capture memory data at the end of a read grant, pulse rvalid once
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
      r_m0_rdata  <= '0;
      r_m1_rdata  <= '0;
    end else begin
      r_m0_rvalid <= w_gnt_m0 && !bus.i_m0_we;
      r_m1_rvalid <= w_gnt_m1 && !bus.i_m1_we;
      if (w_gnt_m0 && !bus.i_m0_we) r_m0_rdata <= bus.i_mem_rdata;
      if (w_gnt_m1 && !bus.i_m1_we) r_m1_rdata <= bus.i_mem_rdata;
    end
  end

  // A pending response is cancelled as soon as reset is asserted
  assign bus.o_m0_gnt    = w_gnt_m0;
  assign bus.o_m1_gnt    = w_gnt_m1;
  assign bus.o_m0_rvalid = r_m0_rvalid && i_rst_n;
  assign bus.o_m1_rvalid = r_m1_rvalid && i_rst_n;
  assign bus.o_m0_rdata  = r_m0_rdata;
  assign bus.o_m1_rdata  = r_m1_rdata;

endmodule
